debug_cmd_sysclk: RTL and testbench

Parametrised system-clock-side command decoder for the on-chip debug slave. It receives the JTAG shift register and IR from the TCK-domain half as quasi-static buses, plus one toggle per Update-IR and Exit1-DR event. It synchronises those events into `clk`, captures the command into `jdo`, and issues exactly one `take_action`/`take_no_action` pulse per command, gated by a core-side ready handshake. It sits between the TCK-side debug slave logic and the CPU OCI/break/trace units, and generalises the fixed 2-bit IR / 38-bit SR decoder to any IR/SR width, with back-pressure and overrun detection.

---
 rtl/debug_cmd_sysclk_pkg.sv | 34 +++
 rtl/debug_cmd_sysclk_if.sv | 38 +++
 rtl/debug_cmd_sysclk_tgl_sync.sv | 30 +++
 rtl/debug_cmd_sysclk.sv | 122 ++++++++++++
 tb/tb_debug_cmd_sysclk.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/debug_cmd_sysclk_pkg.sv
// Shared types and constants for the system-clock side of the debug command path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package debug_cmd_pkg;

    // Command decoder states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        FIRE = 2'd2
    } state_e;

    // Default geometry of the classic Nios II debug slave
    localparam int DEF_SR_W        = 38;
    localparam int DEF_IR_W        = 2;
    localparam int DEF_ACT_BIT     = 37;
    localparam int DEF_SYNC_STAGES = 2;

    // Nios II virtual IR command encodings (A/B/C variants share one IR code
    // and are told apart by SR payload bits further downstream)
    localparam logic [1:0] IR_OCIMEM_A  = 2'b00;
    localparam logic [1:0] IR_OCIMEM_B  = 2'b00;
    localparam logic [1:0] IR_TRACEMEM  = 2'b01;
    localparam logic [1:0] IR_BREAK_A   = 2'b10;
    localparam logic [1:0] IR_BREAK_B   = 2'b10;
    localparam logic [1:0] IR_BREAK_C   = 2'b10;
    localparam logic [1:0] IR_TRACECTRL = 2'b11;

    // Number of one-hot command channels for a given IR width
    function automatic int ncmd(input int ir_w);
        return 1 << ir_w;
    endfunction

endpackage

// File: rtl/debug_cmd_sysclk_if.sv
// Bundle between the TCK-side debug slave / core units and the sysclk decoder.
// Latency: n/a (wiring only).
// Backpressure: cmd_ready from the core side holds captured commands in the decoder.
interface debug_cmd_sysclk_if
    import debug_cmd_pkg::*;
#(
    parameter int SR_W = DEF_SR_W,
    parameter int IR_W = DEF_IR_W
);
    localparam int NCMD = ncmd(IR_W);

    logic [IR_W-1:0] ir_in;
    logic [SR_W-1:0] sr;
    logic            vs_uir_tgl;
    logic            vs_e1dr_tgl;
    logic            cmd_ready;
    logic            ovf_clr;
    logic [SR_W-1:0] jdo;
    logic [IR_W-1:0] ir_q;
    logic [NCMD-1:0] take_action;
    logic [NCMD-1:0] take_no_action;
    logic            cmd_pending;
    logic            overrun;
    logic            uir_seen;

    // Driver side: TCK-domain buses/toggles plus core-side ready and clear
    modport master (
        output ir_in, sr, vs_uir_tgl, vs_e1dr_tgl, cmd_ready, ovf_clr,
        input  jdo, ir_q, take_action, take_no_action, cmd_pending, overrun, uir_seen
    );

    // Decoder side
    modport slave (
        input  ir_in, sr, vs_uir_tgl, vs_e1dr_tgl, cmd_ready, ovf_clr,
        output jdo, ir_q, take_action, take_no_action, cmd_pending, overrun, uir_seen
    );

endinterface

// File: rtl/debug_cmd_sysclk_tgl_sync.sv
// Synchronises a toggle from another clock domain and turns each level change into a pulse.
// Latency: event high between edges SYNC_STAGES-1 and SYNC_STAGES after the new level is sampled.
// Backpressure: none; the source must space toggles at least SYNC_STAGES+3 clk periods apart.
module debug_tgl_sync #(
    parameter int SYNC_STAGES = 2   // legal range 2..4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tgl,
    output logic evt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    // Synchroniser chain followed by one delay flop for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tgl};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    // Any level change at the end of the chain is one event
    assign evt = sync_q[SYNC_STAGES-1] ^ dly_q;

endmodule

// File: rtl/debug_cmd_sysclk.sv
// Sysclk-side debug command decoder: captures SR/IR on synchronised TCK events, emits one pulse per command.
// Latency: capture on edge SYNC_STAGES, pulse on edge SYNC_STAGES+1 when cmd_ready is already high.
// Backpressure: cmd_ready low holds one command in PEND; a further command while pending is dropped and flags overrun.
module debug_cmd_sysclk
    import debug_cmd_pkg::*;
#(
    parameter int SR_W        = DEF_SR_W,
    parameter int IR_W        = DEF_IR_W,
    parameter int ACT_BIT     = DEF_ACT_BIT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              reset_n,
    debug_cmd_sysclk_if.slave bus
);

    localparam int NCMD = ncmd(IR_W);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_PEND = PEND;
    localparam logic [1:0] S_FIRE = FIRE;

    logic            uir_evt;
    logic            e1dr_evt;
    logic            capture;
    logic [1:0]      state_q;
    logic [SR_W-1:0] jdo_q;
    logic [IR_W-1:0] ir_q;
    logic [IR_W-1:0] cmd_ir_q;
    logic            cmd_act_q;
    logic            overrun_q;
    logic            uir_seen_q;
    logic [NCMD-1:0] take_action;
    logic [NCMD-1:0] take_no_action;

    debug_tgl_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .tgl     (bus.vs_uir_tgl),
        .evt     (uir_evt)
    );

    debug_tgl_sync #(.SYNC_STAGES(SYNC_STAGES)) u_e1dr_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .tgl     (bus.vs_e1dr_tgl),
        .evt     (e1dr_evt)
    );

    // A new command is taken whenever the single holding slot is not occupied
    assign capture = e1dr_evt && (state_q != S_PEND);

    // Latch IR at each Update-IR and flag it for one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q       <= '0;
            uir_seen_q <= 1'b0;
        end else begin
            uir_seen_q <= uir_evt;
            if (uir_evt) begin
                ir_q <= bus.ir_in;
            end
        end
    end

    // Command capture; cmd_ir uses the pre-update ir_q so a coincident Update-IR targets the next command
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jdo_q     <= '0;
            cmd_ir_q  <= '0;
            cmd_act_q <= 1'b0;
        end else if (capture) begin
            jdo_q     <= bus.sr;
            cmd_ir_q  <= ir_q;
            cmd_act_q <= bus.sr[ACT_BIT];
        end
    end

    // IDLE -> PEND on capture, PEND -> FIRE on ready, FIRE -> PEND on back-to-back capture else IDLE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (e1dr_evt) state_q <= S_PEND;
                S_PEND:  if (bus.cmd_ready) state_q <= S_FIRE;
                S_FIRE:  state_q <= e1dr_evt ? S_PEND : S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Sticky loss flag: a command arriving while one is pending; setting beats clearing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q <= 1'b0;
        end else if (e1dr_evt && (state_q == S_PEND)) begin
            overrun_q <= 1'b1;
        end else if (bus.ovf_clr) begin
            overrun_q <= 1'b0;
        end
    end

    // One-hot pulse decode, driven only from registered state so it is glitch-free
    always_comb begin
        take_action    = '0;
        take_no_action = '0;
        if (state_q == S_FIRE) begin
            take_action[cmd_ir_q]    = cmd_act_q;
            take_no_action[cmd_ir_q] = !cmd_act_q;
        end
    end

    assign bus.jdo            = jdo_q;
    assign bus.ir_q           = ir_q;
    assign bus.take_action    = take_action;
    assign bus.take_no_action = take_no_action;
    assign bus.cmd_pending    = (state_q == S_PEND);
    assign bus.overrun        = overrun_q;
    assign bus.uir_seen       = uir_seen_q;

endmodule

// File: tb/tb_debug_cmd_sysclk.sv
// Self-checking bench for debug_cmd_sysclk: vector table plus corner-case sequences, pulse scoreboard.
// Latency: n/a.
// Backpressure: exercised through cmd_ready.
module tb_debug_cmd_sysclk;
    import debug_cmd_pkg::*;

    logic clk;
    logic reset_n;

    int checks = 0;
    int errors = 0;

    debug_cmd_sysclk_if #(.SR_W(38), .IR_W(2)) bus ();

    debug_cmd_sysclk #(
        .SR_W(38), .IR_W(2), .ACT_BIT(37), .SYNC_STAGES(2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ir;
        logic [37:0] sr;
        logic [3:0]  ta;
        logic [3:0]  tna;
    } vec_t;

    typedef struct {
        logic [3:0]  ta;
        logic [3:0]  tna;
        logic [37:0] jdo;
    } exp_t;

    vec_t vecs[6];
    exp_t sb_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard: every pulse seen must match the oldest expected command
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && ((bus.take_action | bus.take_no_action) != 4'b0)) begin
            chk("pulse_onehot", 64'($countones({bus.take_action, bus.take_no_action})), 64'd1);
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", {56'd0, bus.take_action, bus.take_no_action}, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_pulse", {56'd0, bus.take_action, bus.take_no_action}, {56'd0, e.ta, e.tna});
                chk("sb_jdo", 64'(bus.jdo), 64'(e.jdo));
            end
        end
    end

    // Full UIR then E1DR sequence with cmd_ready high, checking edge-accurate timing
    task automatic run_cmd(input vec_t v);
        @(negedge clk);
        bus.ir_in      = v.ir;
        bus.vs_uir_tgl = ~bus.vs_uir_tgl;
        repeat (2) @(negedge clk);
        chk("uir_seen_early", 64'(bus.uir_seen), 64'd0);
        @(negedge clk);
        chk("uir_seen_edge2", 64'(bus.uir_seen), 64'd1);
        chk("ir_q_edge2", 64'(bus.ir_q), 64'(v.ir));
        repeat (3) @(negedge clk);
        bus.sr        = v.sr;
        bus.cmd_ready = 1'b1;
        sb_q.push_back('{v.ta, v.tna, v.sr});
        bus.vs_e1dr_tgl = ~bus.vs_e1dr_tgl;
        repeat (2) @(negedge clk);
        chk("pending_early", 64'(bus.cmd_pending), 64'd0);
        @(negedge clk);
        chk("jdo_edge2", 64'(bus.jdo), 64'(v.sr));
        chk("pending_edge2", 64'(bus.cmd_pending), 64'd1);
        @(negedge clk);
        chk("take_action_edge3", 64'(bus.take_action), 64'(v.ta));
        chk("take_no_action_edge3", 64'(bus.take_no_action), 64'(v.tna));
        chk("pending_fire", 64'(bus.cmd_pending), 64'd0);
        @(negedge clk);
        chk("pulse_gone_edge4", 64'(bus.take_action | bus.take_no_action), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{IR_TRACEMEM,  38'h20_0000_1234, 4'b0010, 4'b0000};
        vecs[1] = '{IR_TRACECTRL, 38'h00_0000_1234, 4'b0000, 4'b1000};
        vecs[2] = '{IR_OCIMEM_A,  38'h3F_FFFF_FFFF, 4'b0001, 4'b0000};
        vecs[3] = '{IR_BREAK_A,   38'h1F_FFFF_FFFF, 4'b0000, 4'b0100};
        vecs[4] = '{IR_BREAK_B,   38'h20_0000_0000, 4'b0100, 4'b0000};
        vecs[5] = '{IR_OCIMEM_B,  38'h00_0000_0000, 4'b0000, 4'b0001};

        reset_n         = 1'b0;
        bus.ir_in       = '0;
        bus.sr          = '0;
        bus.vs_uir_tgl  = 1'b0;
        bus.vs_e1dr_tgl = 1'b0;
        bus.cmd_ready   = 1'b0;
        bus.ovf_clr     = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Idle after reset
        repeat (100) @(negedge clk);
        chk("rst_jdo", 64'(bus.jdo), 64'd0);
        chk("rst_ir_q", 64'(bus.ir_q), 64'd0);
        chk("rst_take_action", 64'(bus.take_action), 64'd0);
        chk("rst_take_no_action", 64'(bus.take_no_action), 64'd0);
        chk("rst_pending", 64'(bus.cmd_pending), 64'd0);
        chk("rst_overrun", 64'(bus.overrun), 64'd0);
        chk("rst_uir_seen", 64'(bus.uir_seen), 64'd0);

        // Table-driven commands
        for (int i = 0; i < 6; i++) begin
            run_cmd(vecs[i]);
        end

        // Back-pressure and overrun: IR = 1, first command is an action
        @(negedge clk);
        bus.cmd_ready  = 1'b0;
        bus.ir_in      = 2'd1;
        bus.vs_uir_tgl = ~bus.vs_uir_tgl;
        repeat (6) @(negedge clk);
        bus.sr          = 38'h20_0000_00AA;
        bus.vs_e1dr_tgl = ~bus.vs_e1dr_tgl;
        repeat (3) @(negedge clk);
        chk("bp_pending", 64'(bus.cmd_pending), 64'd1);
        chk("bp_jdo", 64'(bus.jdo), 64'h20_0000_00AA);
        repeat (5) @(negedge clk);
        chk("bp_pending_held", 64'(bus.cmd_pending), 64'd1);
        chk("bp_no_overrun", 64'(bus.overrun), 64'd0);
        // Second command lands while pending, with ovf_clr asserted: set must win
        bus.sr          = 38'h00_0000_0055;
        bus.ovf_clr     = 1'b1;
        bus.vs_e1dr_tgl = ~bus.vs_e1dr_tgl;
        repeat (3) @(negedge clk);
        bus.ovf_clr = 1'b0;
        chk("ovr_set_wins", 64'(bus.overrun), 64'd1);
        chk("ovr_jdo_kept", 64'(bus.jdo), 64'h20_0000_00AA);
        chk("ovr_pending", 64'(bus.cmd_pending), 64'd1);
        repeat (3) @(negedge clk);
        sb_q.push_back('{4'b0010, 4'b0000, 38'h20_0000_00AA});
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        chk("ovr_fire_ta", 64'(bus.take_action), 64'h2);
        bus.cmd_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("ovr_pending_done", 64'(bus.cmd_pending), 64'd0);
        chk("ovr_sticky", 64'(bus.overrun), 64'd1);
        bus.ovf_clr = 1'b1;
        @(negedge clk);
        bus.ovf_clr = 1'b0;
        chk("ovr_cleared", 64'(bus.overrun), 64'd0);

        // Coincident UIR and E1DR: capture uses old ir_q = 0
        bus.ir_in      = 2'd0;
        bus.vs_uir_tgl = ~bus.vs_uir_tgl;
        repeat (6) @(negedge clk);
        chk("sim_old_ir", 64'(bus.ir_q), 64'd0);
        bus.ir_in       = 2'd2;
        bus.sr          = 38'h3F_0000_0001;
        bus.cmd_ready   = 1'b1;
        sb_q.push_back('{4'b0001, 4'b0000, 38'h3F_0000_0001});
        bus.vs_uir_tgl  = ~bus.vs_uir_tgl;
        bus.vs_e1dr_tgl = ~bus.vs_e1dr_tgl;
        repeat (3) @(negedge clk);
        chk("sim_new_ir", 64'(bus.ir_q), 64'd2);
        chk("sim_jdo", 64'(bus.jdo), 64'h3F_0000_0001);
        @(negedge clk);
        chk("sim_ta_bit0", 64'(bus.take_action), 64'h1);
        repeat (5) @(negedge clk);

        // Reset while pending with overrun set
        bus.cmd_ready   = 1'b0;
        bus.sr          = 38'h15_5555_5555;
        bus.vs_e1dr_tgl = ~bus.vs_e1dr_tgl;
        repeat (3) @(negedge clk);
        chk("rstp_pending", 64'(bus.cmd_pending), 64'd1);
        repeat (3) @(negedge clk);
        bus.sr          = 38'h0A_AAAA_AAAA;
        bus.vs_e1dr_tgl = ~bus.vs_e1dr_tgl;
        repeat (3) @(negedge clk);
        chk("rstp_overrun", 64'(bus.overrun), 64'd1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rstp_async_pending", 64'(bus.cmd_pending), 64'd0);
        chk("rstp_async_overrun", 64'(bus.overrun), 64'd0);
        chk("rstp_async_jdo", 64'(bus.jdo), 64'd0);
        bus.vs_uir_tgl  = 1'b0;
        bus.vs_e1dr_tgl = 1'b0;
        bus.cmd_ready   = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rstp_no_pending", 64'(bus.cmd_pending), 64'd0);
        chk("rstp_sb_empty", 64'(sb_q.size()), 64'd0);

        // First command after reset is still detected
        run_cmd(vecs[0]);
        repeat (5) @(negedge clk);
        chk("final_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
